// File: rtl/dmux16_pkg.sv
// Shared types and defaults for the dmux16 stream demultiplexer.
// Width and channel count live here so the top, the slot and any consumer agree.
package dmux16_pkg;

  localparam int DMUX_WIDTH = 16;
  localparam int DMUX_NCH   = 4;
  localparam int DMUX_SELW  = $clog2(DMUX_NCH);

  typedef logic [DMUX_WIDTH-1:0] word_t;
  typedef logic [DMUX_SELW-1:0]  ch_idx_t;
  typedef logic [15:0]           cnt_t;

endpackage

// File: rtl/dmux16_slot.sv
// Single-entry holding slot: one data register plus a full flag.
// A load always wins over a drain, so a slot can be refilled on the edge it empties.
module dmux16_slot
  import dmux16_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // NOTE: state is written with non-blocking assignments so every flop samples
  // pre-edge values; the data register is reset too, because out[k] is visible
  // even while the slot is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (load) begin
      r_data <= d;
      r_full <= 1'b1;
    end else if (drain) begin
      r_full <= 1'b0;
    end
  end

  assign data = r_data;
  assign full = r_full;

endmodule

// File: rtl/dmux16_stream.sv
// Stream demultiplexer: steers each accepted word to the slot chosen by sel,
// with independent per-channel valid/ready drain and a 16-bit accept counter.
module dmux16_stream
  import dmux16_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH,
  parameter int NCH   = DMUX_NCH,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in,
  input  logic [SELW-1:0]           sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NCH-1:0][WIDTH-1:0] out,
  output logic [NCH-1:0]            out_valid,
  input  logic [NCH-1:0]            out_ready,
  output logic [15:0]               xfer_cnt
);

  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_load;
  logic [NCH-1:0] w_drain;
  logic           w_accept;
  cnt_t           r_xfer_cnt;

  // A full slot can still take a word if its consumer empties it on the same edge.
  assign in_ready = !w_full[sel] || out_ready[sel];
  assign w_accept = in_valid && in_ready;
  assign w_drain  = w_full & out_ready;

  // NOTE: the decode vector gets a default before the conditional write so no
  // latch is inferred for the channels that are not selected.
  always_comb begin
    w_load = '0;
    if (w_accept) w_load[sel] = 1'b1;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    dmux16_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_load[k]),
      .drain (w_drain[k]),
      .d     (in),
      .data  (out[k]),
      .full  (w_full[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_accept) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign out_valid = w_full;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_dmux16_stream.sv
// Scoreboard bench for dmux16_stream: per-channel queues of expected words,
// filled from the stimulus side and drained by a negedge monitor.
module tb_dmux16_stream;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      in_data = '0;
  logic [1:0]       sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0][15:0] dout;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [15:0]      xfer_cnt;

  dmux16_stream #(.WIDTH(16), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a slot is a queue of at most one word; last[] is what out[k] shows.
  logic [15:0] exp_q [4][$];
  logic [15:0] last [4];
  logic [15:0] model_cnt = '0;
  logic        mon_en = 1'b0;

  // Stimulus-side prediction for the cycle currently being driven.
  logic        stg_ready = 1'b1;
  logic        stg_acc = 1'b0;
  logic [1:0]  stg_sel = '0;
  logic [15:0] stg_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = ordy;
    stg_ready = (exp_q[s].size() == 0) || ordy[s];
    stg_acc   = v && stg_ready;
    stg_sel   = s;
    stg_word  = d;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last[k] = '0;
    end
    model_cnt = '0;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [15:0] popped;
      check("in_ready", {31'd0, in_ready}, {31'd0, stg_ready});
      check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, model_cnt});
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
              {31'd0, exp_q[k].size() != 0});
        check($sformatf("out[%0d]", k), {16'd0, dout[k]}, {16'd0, last[k]});
        if (exp_q[k].size() != 0 && out_ready[k]) begin
          popped = exp_q[k].pop_front();
          check($sformatf("drain[%0d]", k), {16'd0, dout[k]}, {16'd0, popped});
        end
      end
      if (stg_acc) begin
        exp_q[stg_sel].push_back(stg_word);
        last[stg_sel] = stg_word;
        model_cnt     = model_cnt + 16'd1;
      end
    end
  end

  initial begin
    clear_model();
    #2;
    check("rst out_valid", {28'd0, out_valid}, 32'h0);
    check("rst xfer_cnt", {16'd0, xfer_cnt}, 32'h0);
    check("rst in_ready", {31'd0, in_ready}, 32'h1);
    check("rst out", dout[0] | dout[1] | dout[2] | dout[3], 32'h0);
    #10;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First word to channel 1 appears one cycle later.
    cycle(1'b1, 2'd1, 16'h1234, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("d1 out_valid", {28'd0, out_valid}, 32'b0010);
    check("d1 out[1]", {16'd0, dout[1]}, 32'h1234);
    check("d1 xfer_cnt", {16'd0, xfer_cnt}, 32'd1);

    // Blocked on full channel 1, then the same word redirected to channel 2.
    cycle(1'b1, 2'd1, 16'h9876, 4'b0000);
    #1 check("d2 blocked in_ready", {31'd0, in_ready}, 32'h0);
    cycle(1'b1, 2'd2, 16'h9876, 4'b0000);
    #1 check("d2 open in_ready", {31'd0, in_ready}, 32'h1);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("d2 out[1]", {16'd0, dout[1]}, 32'h1234);
    check("d2 out[2]", {16'd0, dout[2]}, 32'h9876);
    check("d2 xfer_cnt", {16'd0, xfer_cnt}, 32'd2);

    // Drain and refill channel 0 on the same edge.
    cycle(1'b1, 2'd0, 16'hAAAA, 4'b0000);
    cycle(1'b1, 2'd0, 16'h5555, 4'b0001);
    #1 check("d3 in_ready", {31'd0, in_ready}, 32'h1);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("d3 out_valid[0]", {31'd0, out_valid[0]}, 32'h1);
    check("d3 out[0]", {16'd0, dout[0]}, 32'h5555);

    // Fill channel 3, then drain all four at once; data must stay visible.
    cycle(1'b1, 2'd3, 16'hC3C3, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b1111);
    check("d4 all full", {28'd0, out_valid}, 32'b1111);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("d4 out_valid", {28'd0, out_valid}, 32'b0000);
    check("d4 out[0]", {16'd0, dout[0]}, 32'h5555);
    check("d4 out[1]", {16'd0, dout[1]}, 32'h1234);
    check("d4 out[2]", {16'd0, dout[2]}, 32'h9876);
    check("d4 out[3]", {16'd0, dout[3]}, 32'hC3C3);

    // Random traffic; stalled words are not retried, the next cycle is independent.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 4'($urandom));
    end

    // Mid-operation reset with slots 0 and 3 occupied.
    cycle(1'b0, 2'd0, 16'h0000, 4'b1111);
    cycle(1'b1, 2'd0, 16'h1111, 4'b0000);
    cycle(1'b1, 2'd3, 16'h3333, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    check("d5 pre-reset out_valid", {28'd0, out_valid}, 32'b1001);
    #1 rst_n = 1'b0;
    #1;
    check("d5 reset out_valid", {28'd0, out_valid}, 32'b0000);
    check("d5 reset out", dout[0] | dout[1] | dout[2] | dout[3], 32'h0);
    check("d5 reset xfer_cnt", {16'd0, xfer_cnt}, 32'h0);
    check("d5 reset in_ready", {31'd0, in_ready}, 32'h1);
    clear_model();
    stg_ready = 1'b1;
    stg_acc   = 1'b0;
    #1 rst_n = 1'b1;

    // Counter wrap: 65535 accepts reach 0xFFFF, one more returns to 0.
    for (int i = 0; i < 65535; i++) begin
      cycle(1'b1, 2'($urandom), 16'($urandom), 4'b1111);
    end
    cycle(1'b1, 2'($urandom), 16'($urandom), 4'b1111);
    check("d6 xfer_cnt max", {16'd0, xfer_cnt}, 32'hFFFF);
    cycle(1'b0, 2'd0, 16'h0000, 4'b1111);
    check("d6 xfer_cnt wrap", {16'd0, xfer_cnt}, 32'h0000);

    cycle(1'b0, 2'd0, 16'h0000, 4'b0000);
    @(negedge clk);
    #1 mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
